riscv_core_mem_arbiter: RTL and testbench

- Shares the single block-transfer memory port (AXI bridge, one 256-bit line per transaction) between the instruction-cache refill path and the data-cache refill/write-back path.
- Sits between the two cache controllers and the AXI master.
- Latches the winning request, sequences one transaction at a time, and returns completion and line data to the granted requester only.
- Uses fair round-robin arbitration between the two caches.

---
 rtl/riscv_core_mem_arbiter.sv | 126 ++++++++++++
 tb/tb_riscv_core_mem_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_mem_arbiter.sv
// Shares one line-wide memory port between the icache refill path and the
// dcache refill/write-back path. Round-robin arbitration. One transaction
// is in flight at a time. Completion and line data go only to the granted side.
//
// Handshake: each requester raises a level request and holds it until it sees
// its one-cycle done pulse. The arbiter holds o_axi_req high with stable,
// latched command fields until the bridge returns a one-cycle i_axi_done.
// The RESP cycle that follows gives the requester one edge to drop its
// request before the arbiter samples requests again.
module riscv_core_mem_arbiter #(
   parameter int ADDR_WIDTH       = 32,
   parameter int AXI_DATA_WIDTH   = 256,
   parameter int LINE_OFFSET_BITS = 5
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_ic_req,
   input  logic [ADDR_WIDTH-1:0]     i_ic_addr,
   output logic                      o_ic_done,
   output logic [AXI_DATA_WIDTH-1:0] o_ic_block,
   input  logic                      i_dc_req,
   input  logic                      i_dc_we,
   input  logic [ADDR_WIDTH-1:0]     i_dc_addr,
   input  logic [AXI_DATA_WIDTH-1:0] i_dc_wblock,
   output logic                      o_dc_done,
   output logic [AXI_DATA_WIDTH-1:0] o_dc_rblock,
   output logic                      o_axi_req,
   output logic                      o_axi_we,
   output logic [ADDR_WIDTH-1:0]     o_axi_addr,
   output logic [AXI_DATA_WIDTH-1:0] o_axi_wblock,
   input  logic                      i_axi_done,
   input  logic [AXI_DATA_WIDTH-1:0] i_axi_rblock,
   output logic                      o_busy,
   output logic [1:0]                o_dbg_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IC = 2'd1,
      BUSY_DC = 2'd2,
      RESP    = 2'd3
   } state_t;

   // Clears the byte-offset bits so the bridge always sees a line address.
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << LINE_OFFSET_BITS;

   state_t state;
   logic   last_grant_dc;  // 1 = dcache won the most recent grant

   // The icache wins when it is alone or when the dcache was served last.
   logic   pick_ic;
   assign pick_ic = i_ic_req && (!i_dc_req || last_grant_dc);

   assign o_dbg_state = state;

   // Arbitration FSM with registered outputs and latched transaction fields.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state         <= IDLE;
         last_grant_dc <= 1'b1;
         o_ic_done     <= 1'b0;
         o_ic_block    <= '0;
         o_dc_done     <= 1'b0;
         o_dc_rblock   <= '0;
         o_axi_req     <= 1'b0;
         o_axi_we      <= 1'b0;
         o_axi_addr    <= '0;
         o_axi_wblock  <= '0;
         o_busy        <= 1'b0;
      end else begin
         // Done pulses last exactly one cycle.
         o_ic_done <= 1'b0;
         o_dc_done <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_ic) begin
                  state         <= BUSY_IC;
                  last_grant_dc <= 1'b0;
                  o_axi_req     <= 1'b1;
                  o_axi_we      <= 1'b0;
                  o_axi_addr    <= i_ic_addr & LINE_MASK;
                  o_axi_wblock  <= '0;
                  o_busy        <= 1'b1;
               end else if (i_dc_req) begin
                  state         <= BUSY_DC;
                  last_grant_dc <= 1'b1;
                  o_axi_req     <= 1'b1;
                  o_axi_we      <= i_dc_we;
                  o_axi_addr    <= i_dc_addr & LINE_MASK;
                  o_axi_wblock  <= i_dc_wblock;
                  o_busy        <= 1'b1;
               end
            end
            BUSY_IC: begin
               if (i_axi_done) begin
                  state      <= RESP;
                  o_axi_req  <= 1'b0;
                  o_ic_block <= i_axi_rblock;
                  o_ic_done  <= 1'b1;
               end
            end
            BUSY_DC: begin
               if (i_axi_done) begin
                  state     <= RESP;
                  o_axi_req <= 1'b0;
                  o_dc_done <= 1'b1;
                  // A write-back returns no data; keep the last refill line.
                  if (!o_axi_we) begin
                     o_dc_rblock <= i_axi_rblock;
                  end
               end
            end
            RESP: begin
               state  <= IDLE;
               o_busy <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               o_axi_req <= 1'b0;
               o_busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_core_mem_arbiter.sv
// Directed bench for riscv_core_mem_arbiter: single grants, write-back
// stability, round-robin alternation, stray completions, mid-transfer reset
// and early request drop.
module tb_riscv_core_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic          ic_req;
   logic [AW-1:0] ic_addr;
   logic          ic_done;
   logic [DW-1:0] ic_block;
   logic          dc_req;
   logic          dc_we;
   logic [AW-1:0] dc_addr;
   logic [DW-1:0] dc_wblock;
   logic          dc_done;
   logic [DW-1:0] dc_rblock;
   logic          axi_req;
   logic          axi_we;
   logic [AW-1:0] axi_addr;
   logic [DW-1:0] axi_wblock;
   logic          axi_done;
   logic [DW-1:0] axi_rblock;
   logic          busy;
   logic [1:0]    dbg_state;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] pat_a5, pat_5a, pat_11, pat_ee;
   logic [DW-1:0] pats [4];
   logic [AW-1:0] exp_addr;

   riscv_core_mem_arbiter #(
      .ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .LINE_OFFSET_BITS(5)
   ) dut (
      .i_clk(clk), .i_rst(rst),
      .i_ic_req(ic_req), .i_ic_addr(ic_addr),
      .o_ic_done(ic_done), .o_ic_block(ic_block),
      .i_dc_req(dc_req), .i_dc_we(dc_we), .i_dc_addr(dc_addr),
      .i_dc_wblock(dc_wblock),
      .o_dc_done(dc_done), .o_dc_rblock(dc_rblock),
      .o_axi_req(axi_req), .o_axi_we(axi_we), .o_axi_addr(axi_addr),
      .o_axi_wblock(axi_wblock),
      .i_axi_done(axi_done), .i_axi_rblock(axi_rblock),
      .o_busy(busy), .o_dbg_state(dbg_state)
   );

   // Clock: 10 ns period.
   always #5 clk = ~clk;

   // Advance one rising edge, then settle 1 ns so outputs are sampled away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // All outputs at their reset values.
   task automatic chk_all_zero(input string tag);
      chk({tag, "_req"}, axi_req, 0);
      chk({tag, "_we"}, axi_we, 0);
      chk({tag, "_addr"}, axi_addr, 0);
      chk({tag, "_wblk"}, axi_wblock, 0);
      chk({tag, "_icd"}, ic_done, 0);
      chk({tag, "_icb"}, ic_block, 0);
      chk({tag, "_dcd"}, dc_done, 0);
      chk({tag, "_dcb"}, dc_rblock, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_st"}, dbg_state, 0);
   endtask

   initial begin
      pat_a5 = {32{8'hA5}};
      pat_5a = {32{8'h5A}};
      pat_11 = {32{8'h11}};
      pat_ee = {32{8'hEE}};
      pats[0] = {32{8'h01}};
      pats[1] = {32{8'h02}};
      pats[2] = {32{8'h03}};
      pats[3] = {32{8'h04}};

      rst = 1'b1; ic_req = 0; ic_addr = '0; dc_req = 0; dc_we = 0; dc_addr = '0;
      dc_wblock = '0; axi_done = 0; axi_rblock = '0;
      step(); step();
      chk_all_zero("reset");
      rst = 1'b0;

      // Single icache refill.
      ic_req = 1; ic_addr = 32'h0000_1234;
      step();
      chk("ic_req", axi_req, 1);
      chk("ic_addr", axi_addr, 32'h0000_1220);
      chk("ic_we", axi_we, 0);
      chk("ic_busy", busy, 1);
      step();
      chk("ic_wait_req", axi_req, 1);
      chk("ic_wait_done", ic_done, 0);
      axi_done = 1; axi_rblock = pat_a5;
      step();
      chk("ic_done", ic_done, 1);
      chk("ic_block", ic_block, pat_a5);
      chk("ic_dc_quiet", dc_done, 0);
      chk("ic_req_drop", axi_req, 0);
      axi_done = 0; axi_rblock = '0; ic_req = 0;
      step();
      chk("ic_done_pulse", ic_done, 0);
      chk("ic_block_hold", ic_block, pat_a5);
      chk("ic_idle_busy", busy, 0);

      // dcache write-back with input data changing mid-transfer.
      dc_req = 1; dc_we = 1; dc_addr = 32'h8000_0040; dc_wblock = pat_11;
      step();
      chk("wb_req", axi_req, 1);
      chk("wb_we", axi_we, 1);
      chk("wb_addr", axi_addr, 32'h8000_0040);
      chk("wb_wblk", axi_wblock, pat_11);
      dc_wblock = pat_ee; dc_addr = 32'h1234_5678; dc_we = 0;
      step();
      chk("wb_wblk_hold", axi_wblock, pat_11);
      chk("wb_addr_hold", axi_addr, 32'h8000_0040);
      chk("wb_we_hold", axi_we, 1);
      axi_done = 1; axi_rblock = pat_5a;
      step();
      chk("wb_done", dc_done, 1);
      chk("wb_rblock_keep", dc_rblock, 0);
      chk("wb_ic_quiet", ic_done, 0);
      axi_done = 0; dc_req = 0;
      step();
      chk("wb_done_pulse", dc_done, 0);
      chk("wb_idle", busy, 0);

      // Both requesters held: grants alternate IC, DC, IC, DC.
      ic_req = 1; ic_addr = 32'h0000_0100;
      dc_req = 1; dc_we = 0; dc_addr = 32'h2000_0013;
      step();
      for (int k = 0; k < 4; k++) begin
         exp_addr = (k % 2 == 0) ? 32'h0000_0100 : 32'h2000_0000;
         chk($sformatf("rr%0d_req", k), axi_req, 1);
         chk($sformatf("rr%0d_addr", k), axi_addr, exp_addr);
         axi_done = 1; axi_rblock = pats[k];
         step();
         chk($sformatf("rr%0d_icd", k), ic_done, (k % 2 == 0) ? 1 : 0);
         chk($sformatf("rr%0d_dcd", k), dc_done, (k % 2 == 0) ? 0 : 1);
         chk($sformatf("rr%0d_blk", k), (k % 2 == 0) ? ic_block : dc_rblock, pats[k]);
         axi_done = 0;
         if (k == 3) begin
            ic_req = 0; dc_req = 0;
         end
         step();
         chk($sformatf("rr%0d_gap_busy", k), busy, 0);
         chk($sformatf("rr%0d_gap_req", k), axi_req, 0);
         chk($sformatf("rr%0d_gap_dn", k), {ic_done, dc_done}, 0);
         step();
      end
      chk("rr_end_busy", busy, 0);

      // Stray completion while idle.
      axi_done = 1; axi_rblock = pat_ee;
      step();
      chk("stray_idle_busy", busy, 0);
      chk("stray_idle_dn", {ic_done, dc_done}, 0);
      chk("stray_idle_icb", ic_block, pats[2]);
      axi_done = 0;

      // Stray completion during RESP.
      ic_req = 1; ic_addr = 32'h0000_0200;
      step();
      axi_done = 1; axi_rblock = pat_5a;
      step();
      chk("stray_resp_first", ic_done, 1);
      ic_req = 0; axi_rblock = pat_ee;
      step();
      chk("stray_resp_dn", {ic_done, dc_done}, 0);
      chk("stray_resp_busy", busy, 0);
      chk("stray_resp_icb", ic_block, pat_5a);
      axi_done = 0;
      step();
      chk("stray_resp_idle", busy, 0);

      // Reset two cycles into a dcache read.
      dc_req = 1; dc_we = 0; dc_addr = 32'h3000_0000;
      step();
      chk("rst_busy_dc", dbg_state, 2);
      step();
      rst = 1;
      step();
      chk_all_zero("midrst");
      rst = 0; dc_req = 0; axi_done = 1; axi_rblock = pat_a5;
      step();
      chk("midrst_no_done", dc_done, 0);
      chk("midrst_idle", busy, 0);
      axi_done = 0;
      ic_req = 1; ic_addr = 32'h0000_0300; dc_req = 1; dc_addr = 32'h3000_0000;
      step();
      chk("midrst_ic_first", axi_addr, 32'h0000_0300);
      chk("midrst_ic_state", dbg_state, 1);
      axi_done = 1; axi_rblock = pat_11;
      step();
      chk("midrst_ic_done", ic_done, 1);
      axi_done = 0; ic_req = 0; dc_req = 0;
      step();
      step();

      // icache drops its request one cycle after the grant.
      ic_req = 1; ic_addr = 32'h0000_4444;
      step();
      ic_req = 0;
      step();
      chk("drop_req", axi_req, 1);
      chk("drop_addr", axi_addr, 32'h0000_4440);
      axi_done = 1; axi_rblock = pat_ee;
      step();
      chk("drop_done", ic_done, 1);
      chk("drop_blk", ic_block, pat_ee);
      axi_done = 0;
      step();
      chk("drop_pulse", ic_done, 0);
      step();
      chk("drop_no_regrant", axi_req, 0);
      chk("drop_idle", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
